// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline and its stages.
package elastic_pipe_pkg;

  localparam int MAX_DEPTH = 16;

  // Occupancy counter width; a zero-depth pipe still exposes a 1-bit count.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Handshake bundle for the elastic pipeline: upstream push, downstream pop, control.
interface elastic_pipe_if #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
);
  import elastic_pipe_pkg::*;

  logic                        ce;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [cnt_width(DEPTH)-1:0] count;

  modport master (
    output ce, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  ce, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/elastic_stage.sv
// One pipeline slot: valid bit plus payload, payload only captured alongside a valid.
module elastic_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic register pipeline with bubble collapse, clock enable and flush.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  elastic_pipe_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok     = clk ^ rst;
    assign bus.out_data  = bus.in_data;
    assign bus.out_valid = bus.ce & bus.in_valid;
    assign bus.in_ready  = bus.ce & ~bus.flush & bus.out_ready;
    assign bus.count     = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [CW-1:0]    cnt;
    logic             run;

    assign run = bus.ce & ~bus.flush;

    // A stage may move if it is empty or everything downstream of it moves.
    always_comb begin
      logic a;
      adv = '0;
      a   = bus.out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        a      = a | ~v[i];
        adv[i] = a;
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign up_v[i] = bus.in_valid;
        assign up_d[i] = bus.in_data;
      end else begin : g_body
        assign up_v[i] = v[i-1];
        assign up_d[i] = d[i-1];
      end

      elastic_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (run & adv[i]),
        .clear    (bus.ce & bus.flush),
        .up_valid (up_v[i]),
        .up_data  (up_d[i]),
        .valid    (v[i]),
        .data     (d[i])
      );
    end

    always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(v[i]);
    end

    assign bus.in_ready  = run & adv[0];
    assign bus.out_valid = bus.ce & v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.count     = cnt;
  end

endmodule
